fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_if_id_reg.sv | 55 +++++
 rtl/fetch_unit.sv | 86 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Holds the default geometry, the halt opcode, the bubble word and the FSM state type.
package fetch_pkg;

  localparam int unsigned PC_W     = 7;
  localparam logic [4:0]  HALT_OP  = 5'b11111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // The opcode field lives in the top five bits of every instruction word.
  function automatic logic [4:0] opcode_of(input logic [31:0] word);
    return word[31:27];
  endfunction

endpackage

// File: rtl/fetch_if_id_reg.sv
// IF/ID pipeline register: instruction, its address and a valid bit.
// load captures a fetched word, flush inserts a bubble and keeps the old pc, otherwise it holds.
module fetch_if_id_reg #(
  parameter int unsigned PC_W     = fetch_pkg::PC_W,
  parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            flush_i,
  input  logic [31:0]     instr_i,
  input  logic [PC_W-1:0] pc_i,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic            valid_o
);

  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  // flush wins over load so a redirect can never let a wrong-path word through.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state updates use <= so all flops sample pre-edge values together.
    if (rst) begin
      instr_q <= NOP_WORD;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, BOOT/RUN/HALT control and the IF/ID register.
// Branch redirects beat stalls; a halt opcode freezes fetch until reset.
module fetch_unit #(
  parameter int unsigned PC_W     = fetch_pkg::PC_W,
  parameter logic [4:0]  HALT_OP  = fetch_pkg::HALT_OP,
  parameter logic [31:0] NOP_WORD = fetch_pkg::NOP_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [31:0]     imem_data_i,
  output logic [31:0]     instr_o,
  output logic [PC_W-1:0] pc_o,
  output logic            valid_o,
  output logic            halted_o
);

  import fetch_pkg::*;

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            load;
  logic            flush;
  logic            is_halt_word;

  assign is_halt_word = (opcode_of(imem_data_i) == HALT_OP);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (branch_taken_i) begin
          pc_d  = branch_target_i;
          flush = 1'b1;
        end else if (!stall_i) begin
          load = 1'b1;
          // The halt word itself is delivered; PC stays on it so the address is observable.
          if (is_halt_word) state_d = HALT;
          else              pc_d    = pc_q + PC_W'(1);
        end
      end
      // Repeated flushes keep the bubble in place for as long as we sit in HALT.
      HALT: flush = 1'b1;
      default: begin
        state_d = BOOT;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_if_id_reg #(
    .PC_W    (PC_W),
    .NOP_WORD(NOP_WORD)
  ) u_if_id (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .flush_i(flush),
    .instr_i(imem_data_i),
    .pc_i   (pc_q),
    .instr_o(instr_o),
    .pc_o   (pc_o),
    .valid_o(valid_o)
  );

  assign imem_addr_o = pc_q;
  assign halted_o    = (state_q == HALT);

endmodule
